// File: rtl/sequence_generator.sv
// Serial stimulus source for the 101101 detector: latches a pattern word and shifts it out MSB-first.
// Optional overlapping-101101 occurrence counter enabled by defining SEQGEN_MATCH_COUNT_EN.
module sequence_generator #(
  parameter int WIDTH   = 44,
  parameter int LEN_W   = 6,
  parameter int MATCH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               hold,
  output logic               X,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [1:0]         Q
`ifdef SEQGEN_MATCH_COUNT_EN
  ,
  output logic [MATCH_W-1:0] match_cnt
`endif
);

  // state | meaning
  // IDLE  | waiting for start; done pulses here for one cycle
  // SHIFT | last edge emitted a pattern bit
  // PAUSE | last edge was a hold gap
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   pat_q;
  logic [LEN_W-1:0]   rem_q;
  logic [LEN_W-1:0]   rem_idx;
  logic [LEN_W-1:0]   len_clamp;
  logic               bit_nxt;

  assign len_clamp = (len > WIDTH_L) ? WIDTH_L : len;
  assign rem_idx   = rem_q - LEN_W'(1);
  assign bit_nxt   = pat_q[rem_idx];
  assign busy      = (state != IDLE);
  assign Q         = state;

`ifdef SEQGEN_MATCH_COUNT_EN
  logic [5:0] hist;
  logic [5:0] hist_nxt;
  assign hist_nxt = {hist[4:0], bit_nxt};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pat_q <= '0;
      rem_q <= '0;
      X     <= 1'b0;
      valid <= 1'b0;
      done  <= 1'b0;
`ifdef SEQGEN_MATCH_COUNT_EN
      hist      <= '0;
      match_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          valid <= 1'b0;
          X     <= 1'b0;
          if (start) begin
            pat_q <= pattern;
            rem_q <= len_clamp;
            state <= SHIFT;
`ifdef SEQGEN_MATCH_COUNT_EN
            hist      <= '0;
            match_cnt <= '0;
`endif
          end
        end
        default: begin
          // hold takes priority over both shifting and finishing
          if (hold) begin
            valid <= 1'b0;
            X     <= 1'b0;
            state <= PAUSE;
          end else if (rem_q != '0) begin
            X     <= bit_nxt;
            valid <= 1'b1;
            rem_q <= rem_idx;
            state <= SHIFT;
`ifdef SEQGEN_MATCH_COUNT_EN
            hist <= hist_nxt;
            if (hist_nxt == 6'b101101 && match_cnt != '1)
              match_cnt <= match_cnt + MATCH_W'(1);
`endif
          end else begin
            valid <= 1'b0;
            X     <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator; drives randomized transfers against a bit-queue model.
// Define SEQGEN_MATCH_COUNT_EN to also check match_cnt.
module tb_sequence_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [43:0] pattern;
  logic [5:0]  len;
  logic        hold;
  logic        X, valid, busy, done;
  logic [1:0]  Q;
`ifdef SEQGEN_MATCH_COUNT_EN
  logic [7:0]  match_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  sequence_generator dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .hold      (hold),
    .X         (X),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .Q         (Q)
`ifdef SEQGEN_MATCH_COUNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Drives one transfer from an IDLE cycle and checks every cycle until done.
  task automatic run_xfer(input logic [43:0] pat, input int ln, input logic [127:0] hmask,
                          input int start_at, output int cycles, output int nbits);
    int   n, idx, k, exp_cnt;
    logic b[$];
    n = (ln > 44) ? 44 : ln;
    b = {};
    for (int i = n - 1; i >= 0; i--) b.push_back(pat[i]);
    start   = 1'b1;
    pattern = pat;
    len     = 6'(ln);
    hold    = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start   = 1'b0;
    pattern = 44'({$urandom(), $urandom()});
    len     = 6'($urandom_range(0, 63));
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0 || Q !== 2'b01 || done !== 1'b0)
      begin failures++; $display("FAIL start_edge: busy=%b valid=%b Q=%b done=%b, need 1 0 01 0", busy, valid, Q, done); end
    idx = 0; k = 0;
    while (1) begin
      k++;
      if (k > 300) begin
        failures++; $display("FAIL timeout: no done within 300 cycles, need done");
        break;
      end
      hold  = (k < 128) ? hmask[k] : 1'b0;
      start = (k == start_at);
      @(posedge clk); #1;
      checks++;
      if (hold) begin
        if (valid !== 1'b0 || X !== 1'b0 || Q !== 2'b10 || busy !== 1'b1 || done !== 1'b0)
          begin failures++; $display("FAIL gap k=%0d: valid=%b X=%b Q=%b busy=%b done=%b, need 0 0 10 1 0", k, valid, X, Q, busy, done); end
      end else if (idx < n) begin
        if (valid !== 1'b1 || X !== b[idx] || Q !== 2'b01 || busy !== 1'b1 || done !== 1'b0)
          begin failures++; $display("FAIL bit%0d: valid=%b X=%b Q=%b busy=%b done=%b, need 1 %b 01 1 0", idx, valid, X, Q, busy, done, b[idx]); end
        idx++;
      end else begin
        if (done !== 1'b1 || busy !== 1'b0 || Q !== 2'b00 || valid !== 1'b0 || X !== 1'b0)
          begin failures++; $display("FAIL done_cycle k=%0d: done=%b busy=%b Q=%b valid=%b X=%b, need 1 0 00 0 0", k, done, busy, Q, valid, X); end
        break;
      end
    end
    start = 1'b0;
    hold  = 1'b0;
    cycles = k;
    nbits  = idx;
    exp_cnt = 0;
    for (int i = 5; i < n; i++)
      if ({b[i-5], b[i-4], b[i-3], b[i-2], b[i-1], b[i]} == 6'b101101) exp_cnt++;
    if (exp_cnt > 255) exp_cnt = 255;
`ifdef SEQGEN_MATCH_COUNT_EN
    checks++;
    if (match_cnt !== 8'(exp_cnt))
      begin failures++; $display("FAIL match_cnt: got %0d, need %0d", match_cnt, exp_cnt); end
`endif
  endtask

  task automatic test_reset();
    int cyc, nb;
    reset = 1'b0; start = 1'b0; hold = 1'b0; pattern = '0; len = '0;
    #12;
    checks++;
    if ({X, valid, done, busy, Q} !== 6'b0)
      begin failures++; $display("FAIL reset_state: X/valid/done/busy/Q=%b, need 000000", {X, valid, done, busy, Q}); end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; pattern = 44'({$urandom(), $urandom()}); len = 6'd44;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    checks++;
    if ({X, valid, done, busy, Q} !== 6'b0)
      begin failures++; $display("FAIL reset_mid: X/valid/done/busy/Q=%b, need 000000", {X, valid, done, busy, Q}); end
`ifdef SEQGEN_MATCH_COUNT_EN
    checks++;
    if (match_cnt !== 8'd0)
      begin failures++; $display("FAIL reset_match: got %0d, need 0", match_cnt); end
`endif
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || Q !== 2'b00)
        begin failures++; $display("FAIL reset_hold: done=%b Q=%b, need 0 00", done, Q); end
    end
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0)
        begin failures++; $display("FAIL post_reset: done=%b busy=%b, need 0 0", done, busy); end
    end
    run_xfer(44'b101, 3, '0, 0, cyc, nb);
    checks++;
    if (cyc !== 4) begin failures++; $display("FAIL after_reset_len: done at T%0d, need T4", cyc); end
  endtask

  task automatic test_basic();
    int cyc, nb;
    run_xfer(44'b101101, 6, '0, 0, cyc, nb);
    checks++;
    if (cyc !== 7 || nb !== 6) begin failures++; $display("FAIL basic: done T%0d bits %0d, need T7 6", cyc, nb); end
`ifdef SEQGEN_MATCH_COUNT_EN
    @(posedge clk); #1;
    checks++;
    if (match_cnt !== 8'd1) begin failures++; $display("FAIL basic_match_hold: got %0d, need 1", match_cnt); end
`endif
  endtask

  task automatic test_overlap();
    int cyc, nb;
    run_xfer(44'b101101101, 9, '0, 0, cyc, nb);
    checks++;
    if (cyc !== 10 || nb !== 9) begin failures++; $display("FAIL overlap: done T%0d bits %0d, need T10 9", cyc, nb); end
  endtask

  task automatic test_hold();
    int cyc, nb;
    logic [127:0] m;
    m = '0; m[3] = 1'b1; m[4] = 1'b1;
    run_xfer(44'($urandom_range(0, 63)), 6, m, 0, cyc, nb);
    checks++;
    if (cyc !== 9) begin failures++; $display("FAIL hold: done T%0d, need T9", cyc); end
    m = '0; m[7] = 1'b1; m[8] = 1'b1;
    run_xfer(44'($urandom_range(0, 63)), 6, m, 0, cyc, nb);
    checks++;
    if (cyc !== 9) begin failures++; $display("FAIL hold_at_end: done T%0d, need T9", cyc); end
  endtask

  task automatic test_edges();
    int cyc, nb;
    run_xfer(44'({$urandom(), $urandom()}), 0, '0, 0, cyc, nb);
    checks++;
    if (cyc !== 1 || nb !== 0) begin failures++; $display("FAIL len0: done T%0d bits %0d, need T1 0", cyc, nb); end
    run_xfer(44'({$urandom(), $urandom()}), 50, '0, 0, cyc, nb);
    checks++;
    if (cyc !== 45 || nb !== 44) begin failures++; $display("FAIL len50: done T%0d bits %0d, need T45 44", cyc, nb); end
  endtask

  task automatic test_start_busy();
    int cyc, nb;
    run_xfer(44'({$urandom(), $urandom()}), 8, '0, 3, cyc, nb);
    checks++;
    if (cyc !== 9) begin failures++; $display("FAIL start_busy: done T%0d, need T9", cyc); end
  endtask

  task automatic test_back_to_back();
    int cyc, nb;
    run_xfer(44'h2d, 6, '0, 0, cyc, nb);
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL b2b_done: done=%b, need 1", done); end
    run_xfer(44'h16d, 9, '0, 0, cyc, nb);
    checks++;
    if (cyc !== 10) begin failures++; $display("FAIL b2b_second: done T%0d, need T10", cyc); end
  endtask

  task automatic test_random();
    int cyc, nb, ln, n;
    logic [127:0] m;
    for (int t = 0; t < 20; t++) begin
      ln = $urandom_range(0, 50);
      n  = (ln > 44) ? 44 : ln;
      for (int i = 0; i < 128; i++) m[i] = (($urandom_range(0, 4)) == 0);
      m[0] = 1'b0;
      run_xfer(44'({$urandom(), $urandom()}), ln, m, $urandom_range(0, 6), cyc, nb);
      checks++;
      if (nb !== n) begin failures++; $display("FAIL rand%0d_bits: sent %0d, need %0d", t, nb, n); end
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_hold();
    test_edges();
    test_start_busy();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial stimulus source for the 101101 sequence detector. Latches a parallel pattern word and shifts it out MSB-first, one bit per clock, on a single-bit line that connects directly to the detector's `X` input. An input hold inserts idle gaps. An optional built-in counter reports how many overlapping 101101 occurrences were transmitted, so the detector's `Z` pulses can be checked against it.

## Interface
- `WIDTH`, default 44: maximum pattern length in bits.
- `LEN_W`, default 6: width of `len`; must satisfy 2^LEN_W > WIDTH.
- `MATCH_W`, default 8: width of `match_cnt`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a transfer; sampled only in IDLE.
- `pattern`  in  WIDTH  pattern word; latched at the start edge.
- `len`  in  LEN_W  number of bits to send, taken from `pattern[len-1:0]`; latched at the start edge.
- `hold`  in  1  stall request; inserts gap cycles while asserted.
- `X`  out  1  serial data bit.
- `valid`  out  1  `X` carries a pattern bit this cycle.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse after the last bit.
- `Q`  out  2  state code: IDLE=00, SHIFT=01, PAUSE=10.
- `match_cnt`  out  MATCH_W  overlapping 101101 count. Present only with the macro.

## Operation
- **Reset** (`reset`=0, asynchronous):
  - Outputs: `X`, `valid`, `done`, `busy`, `Q`, `match_cnt` all go to 0.
  - Internal: shift register, remaining counter and history cleared; state IDLE.
  - Reset asserted mid-transfer aborts the transfer. No `done` pulse follows.
- **IDLE**:
  - `start`=1 latches `pattern` and `min(len, WIDTH)` into `remaining`, clears history and `match_cnt`, then moves to SHIFT. `valid` stays 0 on this edge.
  - `hold` is ignored in IDLE.
- **SHIFT / PAUSE**, on each edge:
  - `hold`=1: `valid`<=0, `X`<=0, state<=PAUSE. `remaining` is unchanged.
  - `hold`=0 and `remaining`>0: `X`<=bit `remaining-1` of the latched pattern, `valid`<=1, `remaining`<=`remaining-1`, state<=SHIFT.
  - `hold`=0 and `remaining`=0: `valid`<=0, `X`<=0, `done`<=1, state<=IDLE.
- **`start` while `busy`** is ignored. The latched pattern is unaffected by later changes on `pattern`/`len`.
- **`len`=0**: the edge after start goes straight to `done`. No bit is sent.
- **`len`>WIDTH**: clamped to WIDTH.
- **`hold` and `remaining`=0 on the same edge**: `hold` wins, and `done` is delayed until `hold` drops.
- `done` is high for exactly one cycle. `start` may be asserted during the `done` cycle and is accepted (state is IDLE).

## Timing
- Registered outputs, no combinational paths from inputs to outputs.
- Start edge T0. First bit is valid after T1. Bit k (k=0..N-1, MSB first) is valid after edge T(k+1) when there is no hold.
- `done` is high after T(N+1). `busy` is high from after T0 through after T(N+1)−1 ... i.e. `busy` is 0 in the `done` cycle.
- Back-to-back transfers: minimum period N+2 cycles.
- Each hold cycle adds exactly one cycle with `valid`=0 and `X`=0.

## Configuration
- Macro: `SEQGEN_MATCH_COUNT_EN`.
- **Defined**:
  - Each emitted bit is shifted into a 6-bit history.
  - `match_cnt` increments when the updated history equals 101101. Overlap is allowed, the count saturates at all-ones, and it is cleared at start.
  - Gap cycles do not affect the history.
  - `match_cnt` holds its value after `done` until the next start or reset.
- **Undefined**: the history and `match_cnt` logic and port are absent. All other behaviour is identical.

## Test plan
- Reset mid-transfer: with `len`=44 and `reset` pulled low after 10 bits:
  - all outputs 0 immediately, `Q`=00;
  - no `done`;
  - the next start with `len`=3, `pattern`=3'b101 sends 1,0,1.
- Basic run: `pattern`=6'b101101, `len`=6, start at T0 ->
  - `valid` high after T1..T6 with `X`=1,0,1,1,0,1;
  - `done` pulse after T7;
  - `match_cnt`=1.
- Overlap: `pattern`=9'b101101101, `len`=9 -> 9 valid bits, `match_cnt`=2, `done` after T10.
- Hold: `len`=6, `hold`=1 for edges T3–T4 ->
  - `valid`=0 and `Q`=10 for two cycles;
  - bit sequence unchanged;
  - `done` after T9.
- Edge cases:
  - `len`=0 -> `done` after T1 with no valid bits;
  - `len`=50 -> exactly 44 bits sent;
  - `start` at T3 of a busy transfer -> ignored.
